sync_fifo_flags: RTL

//   Parametrised single-clock FIFO, next generation of the team's sync FIFO.

---
 rtl/sync_fifo_flags.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/sync_fifo_flags.sv
// sync_fifo_flags
//   Single-clock FIFO of any depth (not limited to powers of two), with a
//   selectable standard or first-word-fall-through (FWFT) read mode. It also
//   provides programmable almost-full / almost-empty flags, an occupancy
//   count and overflow / underflow strobes.
//
// Ports
//   clk           rising-edge clock
//   rst           asynchronous active-high reset
//   wr_en, din    write request and data; accepted when not full
//   rd_en         read request (FWFT: acknowledge of the word on dout)
//   dout          registered read data
//   rd_valid      standard: dout updated this cycle; FWFT: word present on dout
//   full, empty   capacity flags
//   almost_full   count >= AF_THRESH
//   almost_empty  count <= AE_THRESH
//   count         words held (FWFT: includes the word in the output register)
//   overflow      one-cycle strobe after a cycle with wr_en while full
//   underflow     one-cycle strobe after a cycle with rd_en while empty
//
// Output register FSM (only moves when FWFT=1)
//   state    | meaning
//   ST_EMPTY | dout holds no unread word
//   ST_VALID | dout holds the oldest word, waiting for rd_en
module sync_fifo_flags #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = 12,
  parameter int AE_THRESH  = 2,
  localparam int CW        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW-1:0] PTR_LAST = AW'(FIFO_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] AF_C     = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C     = CW'(AE_THRESH);
  localparam logic [CW-1:0] ONE_C    = CW'(1);

  typedef enum logic {ST_EMPTY = 1'b0, ST_VALID = 1'b1} state_t;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         mem_cnt_q;
  logic [DATA_WIDTH-1:0] dout_q;
  logic                  rv_q;
  logic                  ovf_q, udf_q;
  state_t                state_q, state_d;
  logic                  wr_acc, rd_acc, load;

  // Total occupancy drives full; empty means "nothing readable", which in
  // FWFT mode is the output register rather than the memory.
  assign full  = (count_q == DEPTH_C);
  assign empty = (FWFT != 0) ? (state_q == ST_EMPTY) : (count_q == '0);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  // load: move the oldest memory word into dout. Standard mode loads on
  // every accepted read. FWFT mode prefetches whenever the output register
  // is empty or being popped, and only from words already in memory
  // before this edge, so a same-edge write never bypasses to dout.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (FWFT != 0) begin
      if ((state_q == ST_EMPTY || rd_acc) && mem_cnt_q != '0) begin
        load    = 1'b1;
        state_d = ST_VALID;
      end else if (rd_acc) begin
        state_d = ST_EMPTY;
      end
    end else begin
      load = rd_acc;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_EMPTY;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      mem_cnt_q <= '0;
      dout_q    <= '0;
      rv_q      <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      rv_q    <= rd_acc;
      ovf_q   <= wr_en && full;
      udf_q   <= rd_en && empty;

      if (wr_acc) begin
        wr_ptr_q <= (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + AW'(1);
      end
      if (load) begin
        dout_q   <= mem[rd_ptr_q];
        rd_ptr_q <= (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + AW'(1);
      end

      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase

      case ({wr_acc, load})
        2'b10:   mem_cnt_q <= mem_cnt_q + ONE_C;
        2'b01:   mem_cnt_q <= mem_cnt_q - ONE_C;
        default: mem_cnt_q <= mem_cnt_q;
      endcase
    end
  end

  // Storage is not reset; the pointers and counters define validity.
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr_q] <= din;
    end
  end

  assign dout         = dout_q;
  assign rd_valid     = (FWFT != 0) ? (state_q == ST_VALID) : rv_q;
  assign count        = count_q;
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
